melody_seq: RTL and testbench
=============================

// Module: melody_seq
// PURPOSE
//  Melody sequencer that sits directly upstream of the piezo note generator.
//  Steps through a fixed 16-entry song ROM and drives the generator's one-hot
//  5-bit note select for a programmed number of beats per note.
//  Inserts a short silent gap after every note so that repeated notes are
//  articulated. Supports one-shot or looped playback, stop/abort, a busy
//  flag and a done pulse.
// PARAMETERS
//  TICKS_PER_BEAT  25_000_000  clk cycles per beat (250 ms at 100 MHz)
//  GAP_TICKS       2_500_000   silent cycles at end of each entry; must be >= 1 and < TICKS_PER_BEAT
// PORTS
//  clk      in   1  system clock (100 MHz)
//  rst      in   1  asynchronous, active-high reset
//  start    in   1  1-cycle pulse; begins playback at entry 0 when idle
//  stop     in   1  1-cycle pulse; aborts playback
//  loop     in   1  level; 1 = restart at entry 0 after END instead of finishing
//  noteSel  out  5  one-hot note to generator: b0 C, b1 D, b2 E, b3 G, b4 A; 0 = silent
//  busy     out  1  high while not IDLE
//  done     out  1  1-cycle pulse when a one-shot song completes
//  noteIdx  out  4  current ROM entry index
// BEHAVIOUR
//  - Reset (async): state IDLE, noteSel=0, busy=0, done=0, noteIdx=0, all counters=0.
//  - ROM entry is 6 bits: [5:3] code, [2:0] beats.
//  - Code mapping: 0 C, 1 D, 2 E, 3 G, 4 A, 5 REST, 6 REST, 7 END.
//  - A beats value of 0 is treated as 1.
//  - ROM contents, idx 0..13:
//      G1 G1 A1 A1 G1 G1 E2 G1 G1 E1 E1 D3 REST1 END
//  - Entries 14..15 are END.
//  - All outputs are registered.
//  - FSM states: IDLE, NOTE, GAP.
//  - IDLE: on start (and no stop), the next cycle enters NOTE with noteIdx=0,
//    and noteSel shows entry 0's note on that same cycle (1-cycle latency
//    from start). start is ignored in NOTE and GAP.
//  - NOTE: noteSel = decoded one-hot; 0 for REST.
//    Duration = beats*TICKS_PER_BEAT - GAP_TICKS cycles, then go to GAP.
//  - GAP: noteSel=0 for GAP_TICKS cycles. Then noteIdx is incremented
//    (4-bit wrap 15->0) and the next entry is evaluated.
//  - Entry evaluation: an entry that is not END enters NOTE. An END entry
//    (or wrap to 0 from 15) is handled as follows:
//      loop=1: noteIdx=0, enter NOTE with entry 0, no done.
//      loop=0: enter IDLE, done=1 for exactly that cycle, busy=0, noteIdx=0.
//  - Net effect: every entry occupies exactly beats*TICKS_PER_BEAT cycles.
//  - loop is sampled only at END evaluation.
//  - stop in NOTE or GAP: next cycle enters IDLE, noteSel=0, busy=0,
//    noteIdx=0, done stays 0. stop in IDLE has no effect.
//  - stop and start in the same cycle: stop wins.
//  - Beat-length arithmetic: compute in 32 bits; no overflow for beats <= 7
//    at default parameters.
// TESTING (bench uses TICKS_PER_BEAT=10, GAP_TICKS=2)
//  1 Assert rst mid-sim -> noteSel=0, busy=0, done=0, noteIdx=0 immediately,
//    without waiting for a clk edge.
//  2 start pulse at cycle T:
//    - T+1..T+8:   noteSel=5'b01000, busy=1
//    - T+9..T+10:  noteSel=0
//    - T+11:       noteSel=5'b01000, noteIdx=1
//  3 loop=0, full song:
//    - idx6 E: 18 cycles of 5'b00100
//    - idx11 D: 28 cycles of 5'b00010
//    - idx12: 10 silent cycles
//    - done high exactly once, at T+161; busy=0 from T+161
//  4 loop=1, full song:
//    - at T+161, noteSel=5'b01000 and noteIdx=0; done never asserted
//    - then drop loop and check the next pass ends with done at T+321
//  5 stop at T+5 (mid-note):
//    - T+6: noteSel=0, busy=0, noteIdx=0, done=0
//    - start at T+20 -> T+21 noteSel=5'b01000, noteIdx=0
//  6 Same-cycle start+stop in IDLE -> stays IDLE.
//    start pulse during NOTE at idx3 -> ignored, timing unchanged.

Source files
------------

// File: rtl/melody_seq.sv
// Melody sequencer for the piezo note generator.
// Plays a fixed 16-entry song ROM. Each entry drives a one-hot note for
// beats*TICKS_PER_BEAT cycles. The last GAP_TICKS cycles of each entry are
// silent, so repeated notes are heard as separate notes.
module melody_seq #(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  // Must be >= 1 and < TICKS_PER_BEAT.
  parameter int unsigned GAP_TICKS      = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [4:0] noteSel,
  output logic       busy,
  output logic       done,
  output logic [3:0] noteIdx
);

  typedef enum logic [1:0] {StIdle, StNote, StGap} stateT;

  localparam logic [2:0] CodeEnd = 3'd7;

  stateT       state;
  logic [31:0] cnt;

  logic [3:0]  nextIdx;
  logic [5:0]  curEntry;
  logic [5:0]  nextEntry;
  logic [5:0]  firstEntry;
  logic [31:0] noteCycles;
  logic        nextIsEnd;

  // Song ROM: [5:3] note code, [2:0] beats.
  function automatic logic [5:0] romEntry(input logic [3:0] idx);
    logic [5:0] e;
    case (idx)
      4'd0:    e = {3'd3, 3'd1};  // G1
      4'd1:    e = {3'd3, 3'd1};  // G1
      4'd2:    e = {3'd4, 3'd1};  // A1
      4'd3:    e = {3'd4, 3'd1};  // A1
      4'd4:    e = {3'd3, 3'd1};  // G1
      4'd5:    e = {3'd3, 3'd1};  // G1
      4'd6:    e = {3'd2, 3'd2};  // E2
      4'd7:    e = {3'd3, 3'd1};  // G1
      4'd8:    e = {3'd3, 3'd1};  // G1
      4'd9:    e = {3'd2, 3'd1};  // E1
      4'd10:   e = {3'd2, 3'd1};  // E1
      4'd11:   e = {3'd1, 3'd3};  // D3
      4'd12:   e = {3'd5, 3'd1};  // REST1
      default: e = {CodeEnd, 3'd0};
    endcase
    return e;
  endfunction

  // Note code to one-hot select; rests and END are silent.
  function automatic logic [4:0] decodeNote(input logic [2:0] code);
    logic [4:0] sel;
    case (code)
      3'd0:    sel = 5'b00001;
      3'd1:    sel = 5'b00010;
      3'd2:    sel = 5'b00100;
      3'd3:    sel = 5'b01000;
      3'd4:    sel = 5'b10000;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

  // Audible part of an entry: whole entry length minus the trailing gap.
  function automatic logic [31:0] soundCycles(input logic [2:0] beats);
    logic [2:0] b;
    b = (beats == 3'd0) ? 3'd1 : beats;
    return 32'(b) * TICKS_PER_BEAT - GAP_TICKS;
  endfunction

  // Decode the current and the following ROM entry.
  always_comb begin
    nextIdx    = noteIdx + 4'd1;
    curEntry   = romEntry(noteIdx);
    nextEntry  = romEntry(nextIdx);
    firstEntry = romEntry(4'd0);
    noteCycles = soundCycles(curEntry[2:0]);
    // Wrapping 15->0 counts as the end of the song.
    nextIsEnd  = (nextEntry[5:3] == CodeEnd) || (nextIdx == 4'd0);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      noteSel <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      noteIdx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !stop) begin
            state   <= StNote;
            cnt     <= '0;
            noteIdx <= '0;
            noteSel <= decodeNote(firstEntry[5:3]);
            busy    <= 1'b1;
          end
        end
        StNote: begin
          if (stop) begin
            state   <= StIdle;
            cnt     <= '0;
            noteSel <= '0;
            busy    <= 1'b0;
            noteIdx <= '0;
          end else if (cnt == noteCycles - 32'd1) begin
            state   <= StGap;
            cnt     <= '0;
            noteSel <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        StGap: begin
          if (stop) begin
            state   <= StIdle;
            cnt     <= '0;
            noteSel <= '0;
            busy    <= 1'b0;
            noteIdx <= '0;
          end else if (cnt == GAP_TICKS - 32'd1) begin
            cnt <= '0;
            if (!nextIsEnd) begin
              state   <= StNote;
              noteIdx <= nextIdx;
              noteSel <= decodeNote(nextEntry[5:3]);
            end else if (loop) begin
              state   <= StNote;
              noteIdx <= '0;
              noteSel <= decodeNote(firstEntry[5:3]);
            end else begin
              state   <= StIdle;
              noteIdx <= '0;
              noteSel <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= StIdle;
          cnt     <= '0;
          noteSel <= '0;
          busy    <= 1'b0;
          noteIdx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq with short beat timing (10 ticks, gap 2).
// Cycle k counts clock periods after the cycle in which start was pulsed;
// outputs are sampled and inputs driven on the falling edge.
module tb_melody_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop;
  logic [4:0] noteSel;
  logic       busy;
  logic       done;
  logic [3:0] noteIdx;

  int checks   = 0;
  int failures = 0;
  int doneSeen;

  // Hand-written song: one-hot note and beats for entries 0..12.
  logic [4:0] noteTab [13] = '{5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b01000, 5'b01000,
                               5'b00100, 5'b01000, 5'b01000, 5'b00100, 5'b00100, 5'b00010,
                               5'b00000};
  int beatsTab [13] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 3, 1};

  melody_seq #(
    .TICKS_PER_BEAT(10),
    .GAP_TICKS     (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .loop   (loop),
    .noteSel(noteSel),
    .busy   (busy),
    .done   (done),
    .noteIdx(noteIdx)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected note at cycle k (1..160) of one pass through the song.
  function automatic logic [4:0] expSel(input int k);
    int s;
    int len;
    s = 1;
    for (int e = 0; e < 13; e++) begin
      len = beatsTab[e] * 10;
      if (k < s + len) return (k >= s + len - 2) ? 5'd0 : noteTab[e];
      s += len;
    end
    return 5'd0;
  endfunction

  function automatic logic [3:0] expIdx(input int k);
    int s;
    s = 1;
    for (int e = 0; e < 13; e++) begin
      s += beatsTab[e] * 10;
      if (k < s) return 4'(e);
    end
    return 4'd0;
  endfunction

  // Pulse start; returns at the falling edge of cycle T+1.
  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, ".sel"}, 32'(noteSel), 32'd0);
    checkEq({tag, ".busy"}, 32'(busy), 32'd0);
    checkEq({tag, ".done"}, 32'(done), 32'd0);
    checkEq({tag, ".idx"}, 32'(noteIdx), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    loop  = 1'b0;
    #12;
    checkIdle("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("postReset");

    // First two entries, exact cycle-by-cycle timing.
    pulseStart();
    for (int k = 1; k <= 11; k++) begin
      if (k <= 8) begin
        checkEq($sformatf("firstNote.sel k=%0d", k), 32'(noteSel), 32'h08);
        checkEq($sformatf("firstNote.busy k=%0d", k), 32'(busy), 32'd1);
      end else if (k <= 10) begin
        checkEq($sformatf("firstGap.sel k=%0d", k), 32'(noteSel), 32'd0);
        checkEq($sformatf("firstGap.idx k=%0d", k), 32'(noteIdx), 32'd0);
      end else begin
        checkEq("secondNote.sel", 32'(noteSel), 32'h08);
        checkEq("secondNote.idx", 32'(noteIdx), 32'd1);
      end
      @(negedge clk);
    end
    // Finish the one-shot song and check the rest of it against the table.
    doneSeen = 0;
    for (int k = 12; k <= 165; k++) begin
      if (k <= 160) begin
        checkEq($sformatf("oneShot.sel k=%0d", k), 32'(noteSel), 32'(expSel(k)));
        checkEq($sformatf("oneShot.idx k=%0d", k), 32'(noteIdx), 32'(expIdx(k)));
        checkEq($sformatf("oneShot.busy k=%0d", k), 32'(busy), 32'd1);
      end else begin
        checkEq($sformatf("oneShot.end.busy k=%0d", k), 32'(busy), 32'd0);
        checkEq($sformatf("oneShot.end.sel k=%0d", k), 32'(noteSel), 32'd0);
      end
      checkEq($sformatf("oneShot.done k=%0d", k), 32'(done), (k == 161) ? 32'd1 : 32'd0);
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkEq("oneShot.doneCount", 32'(doneSeen), 32'd1);

    // Looped playback, then drop loop during the second pass.
    loop = 1'b1;
    pulseStart();
    doneSeen = 0;
    for (int k = 1; k <= 322; k++) begin
      if (k <= 320) begin
        checkEq($sformatf("loop.sel k=%0d", k), 32'(noteSel), 32'(expSel((k - 1) % 160 + 1)));
        checkEq($sformatf("loop.idx k=%0d", k), 32'(noteIdx), 32'(expIdx((k - 1) % 160 + 1)));
        checkEq($sformatf("loop.busy k=%0d", k), 32'(busy), 32'd1);
        if (done) doneSeen++;
      end
      if (k == 161) begin
        checkEq("loop.wrap.sel", 32'(noteSel), 32'h08);
        checkEq("loop.wrap.idx", 32'(noteIdx), 32'd0);
        loop = 1'b0;
      end
      if (k == 321) begin
        checkEq("loopEnd.done", 32'(done), 32'd1);
        checkEq("loopEnd.busy", 32'(busy), 32'd0);
        checkEq("loopEnd.idx", 32'(noteIdx), 32'd0);
      end
      if (k == 322) checkEq("loopEnd.donePulse", 32'(done), 32'd0);
      @(negedge clk);
    end
    checkEq("loop.noDone", 32'(doneSeen), 32'd0);

    // Stop mid-note, then restart.
    pulseStart();
    for (int k = 1; k <= 21; k++) begin
      if (k == 6) checkIdle("stop");
      if (k == 10) checkIdle("stopped");
      if (k == 21) begin
        checkEq("restart.sel", 32'(noteSel), 32'h08);
        checkEq("restart.idx", 32'(noteIdx), 32'd0);
        checkEq("restart.busy", 32'(busy), 32'd1);
      end
      stop  = (k == 5);
      start = (k == 20);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("stop2");

    // start and stop together in idle: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkIdle("startStop");
    repeat (3) @(negedge clk);
    checkIdle("startStopLater");

    // start during entry 3 is ignored.
    pulseStart();
    for (int k = 1; k <= 60; k++) begin
      checkEq($sformatf("ignore.sel k=%0d", k), 32'(noteSel), 32'(expSel(k)));
      checkEq($sformatf("ignore.idx k=%0d", k), 32'(noteIdx), 32'(expIdx(k)));
      start = (k == 33);
      @(negedge clk);
    end

    // Asynchronous reset mid-note, between clock edges.
    #1;
    rst = 1'b1;
    #1;
    checkIdle("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("afterAsyncReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
